// File: rtl/imem_loader.sv
// Serial-byte program loader: takes a word count and little-endian instruction bytes,
// writes them word by word into instruction memory while holding the core in reset.
module imem_loader #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // state | meaning
   // IDLE  | waiting for load_start; core released
   // LEN   | waiting for the word-count byte
   // DATA  | assembling and writing instruction words
   typedef enum logic [1:0] {IDLE, LEN, DATA} state_t;

   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t         state_q, state_d;
   logic [CW-1:0]  len_q, len_d;
   logic [CW-1:0]  word_idx_q, word_idx_d;
   logic [1:0]     byte_idx_q, byte_idx_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [23:0]    shift_q, shift_d;
   logic           wr_en_q, wr_en_d;
   logic [31:0]    wr_addr_q, wr_addr_d;
   logic [31:0]    wr_data_q, wr_data_d;
   logic           done_q, done_d;
   logic           err_q, err_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         timer_q    <= '0;
         shift_q    <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         timer_q    <= timer_d;
         shift_q    <= shift_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      timer_d    = timer_q;
      shift_d    = shift_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      done_d     = done_q;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d    = LEN;
               done_d     = 1'b0;
               err_d      = 1'b0;
               word_idx_d = '0;
               byte_idx_d = '0;
               timer_d    = '0;
            end
         end
         LEN, DATA: begin
            if (rx_valid) begin
               timer_d = '0;
               if (state_q == LEN) begin
                  if (rx_data == 8'd0 || {24'd0, rx_data} > 32'(DEPTH)) begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                  end else begin
                     len_d   = rx_data[CW-1:0];
                     state_d = DATA;
                  end
               end else if (byte_idx_q == 2'd3) begin
                  // Write is registered, so the last word's strobe coincides with IDLE.
                  wr_en_d    = 1'b1;
                  wr_data_d  = {rx_data, shift_q};
                  wr_addr_d  = {{(30-CW){1'b0}}, word_idx_q, 2'b00};
                  word_idx_d = word_idx_q + CW'(1);
                  byte_idx_d = '0;
                  if (word_idx_q == len_q - CW'(1)) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  shift_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = (state_q != IDLE);
   assign cpu_reset = (state_q != IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: byte streams are checked against a word-level
// reference model of the load protocol.
module tb_imem_loader;
   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        err;

   imem_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .load_start(load_start), .rx_data(rx_data),
      .rx_valid(rx_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int nerr = 0;
   int nchk = 0;

   logic [7:0]  stim_q[$];
   logic [63:0] got_q[$];
   logic        got_busy_q[$];
   logic [63:0] exp_q[$];
   logic        exp_done;
   logic        exp_err;
   logic [63:0] last_wr = '0;

   always @(negedge clk) begin
      if (wr_en) begin
         got_q.push_back({wr_addr, wr_data});
         got_busy_q.push_back(busy);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: count byte, then whole little-endian words at addresses 4*i.
   function automatic void model();
      int n, full;
      exp_q.delete();
      n = int'(stim_q[0]);
      if (n == 0 || n > DEPTH) begin
         exp_err  = 1'b1;
         exp_done = 1'b0;
         return;
      end
      full = (stim_q.size() - 1) / 4;
      if (full > n) full = n;
      for (int i = 0; i < full; i++)
         exp_q.push_back({32'(i * 4), stim_q[4*i+4], stim_q[4*i+3], stim_q[4*i+2], stim_q[4*i+1]});
      exp_done = (full == n);
      exp_err  = !exp_done;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid   = 1'b0;
      load_start = 1'b0;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic check_load(input string tag);
      int n;
      model();
      for (int i = 0; i < TIMEOUT + 8; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      repeat (2) @(negedge clk);
      chk({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
         chk($sformatf("%s_busy_at_wr%0d", tag, i), 64'(got_busy_q[i]),
             (exp_done && i == exp_q.size() - 1) ? 64'd0 : 64'd1);
      end
      if (exp_q.size() > 0) last_wr = exp_q[exp_q.size()-1];
      chk({tag, "_done"}, 64'(done), 64'(exp_done));
      chk({tag, "_err"}, 64'(err), 64'(exp_err));
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_cpurst"}, 64'(cpu_reset), 64'd0);
      chk({tag, "_hold"}, {wr_addr, wr_data}, last_wr);
      got_q.delete();
      got_busy_q.delete();
   endtask

   // Sends the whole stim_q after load_start; inject >= 0 pulses load_start with that byte.
   task automatic run_load(input string tag, input int gap_max, input int inject);
      got_q.delete();
      got_busy_q.delete();
      start_load();
      for (int i = 0; i < stim_q.size(); i++) begin
         repeat ($urandom_range(gap_max, 0)) tick();
         if (i == inject) load_start = 1'b1;
         send_byte(stim_q[i]);
      end
      check_load(tag);
   endtask

   task automatic rand_stim(input int n);
      stim_q.delete();
      stim_q.push_back(8'(n));
      if (n >= 1 && n <= DEPTH)
         for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom_range(255, 0)));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {wr_en, busy, done, err, cpu_reset}, 64'd0);
      chk("rst_addr_data", {wr_addr, wr_data}, 64'd0);
      reset = 1'b0;
      tick();

      // Bytes in IDLE must do nothing.
      for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(255, 0)));
      repeat (2) @(negedge clk);
      chk("idle_rx_nwr", 64'(got_q.size()), 64'd0);
      chk("idle_rx_busy", 64'(busy), 64'd0);

      // Reference program, back-to-back bytes.
      stim_q = '{8'h02, 8'h33, 8'h02, 8'h11, 8'h00, 8'hB3, 8'h02, 8'h11, 8'h40};
      got_q.delete(); got_busy_q.delete();
      start_load();
      foreach (stim_q[i]) send_byte(stim_q[i]);
      repeat (3) @(negedge clk);
      chk("ref_w0", (got_q.size() > 0) ? got_q[0] : 64'hX, 64'h00000000_00110233);
      chk("ref_w1", (got_q.size() > 1) ? got_q[1] : 64'hX, 64'h00000004_401102B3);
      check_load("ref");

      stim_q = '{8'h00};
      run_load("len0", 2, -1);
      stim_q = '{8'h11};
      run_load("len17", 2, -1);

      // Timeout after a partial word.
      stim_q = '{8'h01, 8'hAA, 8'h55};
      got_q.delete(); got_busy_q.delete();
      start_load();
      foreach (stim_q[i]) send_byte(stim_q[i]);
      repeat (TIMEOUT - 1) @(posedge clk);
      @(negedge clk);
      chk("tmo_early_err", 64'(err), 64'd0);
      chk("tmo_early_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("tmo_err", 64'(err), 64'd1);
      check_load("tmo");

      // Full depth, rx_valid every cycle.
      rand_stim(DEPTH);
      run_load("full", 0, -1);

      // Reset mid-load after the 2nd data byte.
      rand_stim(2);
      got_q.delete(); got_busy_q.delete();
      start_load();
      for (int i = 0; i < 3; i++) send_byte(stim_q[i]);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_outs", {wr_en, busy, done, err, cpu_reset}, 64'd0);
      chk("mid_rst_addr_data", {wr_addr, wr_data}, 64'd0);
      tick();
      reset = 1'b0;
      last_wr = '0;
      repeat (TIMEOUT + 4) tick();
      chk("mid_rst_nwr", 64'(got_q.size()), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      rand_stim(3);
      run_load("after_rst", 1, -1);

      // load_start during DATA is ignored.
      rand_stim(3);
      run_load("ls_in_data", 1, 6);

      for (int t = 0; t < 12; t++) begin
         rand_stim($urandom_range(DEPTH + 2, 0));
         run_load($sformatf("rnd%0d", t), 3, ($urandom_range(1, 0) != 0) ? 5 : -1);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
